head_table_lookup: RTL and testbench

- Front stage of the hash-table pipeline.
- Accepts a command (key, value, cmd), hashes the key to a bucket, and reads the bucket's chain head pointer from an internal head-table memory.
- Emits a data task (key, value, cmd, bucket, head_ptr, head_ptr_val) to the data-table stages (search/insert/delete).
- Owns the head table: clears it after reset and accepts head-pointer updates from the downstream insert/delete stages.

---
 rtl/head_table_lookup.sv | 118 +++++++++++
 tb/tb_head_table_lookup.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/head_table_lookup.sv
// Hash-table front stage: hashes the command key to a bucket, reads the chain head
// from the head table and presents a registered task to the data-table stages.
module head_table_lookup #(
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 16,
    parameter int CMD_WIDTH      = 2,
    parameter int BUCKET_WIDTH   = 8,
    parameter int HEAD_PTR_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [KEY_WIDTH-1:0]      cmd_key_i,
    input  logic [VALUE_WIDTH-1:0]    cmd_value_i,
    input  logic [CMD_WIDTH-1:0]      cmd_cmd_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    output logic [KEY_WIDTH-1:0]      task_key_o,
    output logic [VALUE_WIDTH-1:0]    task_value_o,
    output logic [CMD_WIDTH-1:0]      task_cmd_o,
    output logic [BUCKET_WIDTH-1:0]   task_bucket_o,
    output logic [HEAD_PTR_WIDTH-1:0] task_head_ptr_o,
    output logic                      task_head_ptr_val_o,
    output logic                      task_valid_o,
    input  logic                      task_ready_i,
    input  logic                      wr_en_i,
    input  logic [BUCKET_WIDTH-1:0]   wr_bucket_i,
    input  logic [HEAD_PTR_WIDTH-1:0] wr_head_ptr_i,
    input  logic                      wr_head_ptr_val_i,
    output logic                      init_done_o
);
    localparam int DEPTH = 1 << BUCKET_WIDTH;
    localparam int NSL   = (KEY_WIDTH + BUCKET_WIDTH - 1) / BUCKET_WIDTH;

    localparam logic [0:0] INIT_S = 1'b0;
    localparam logic [0:0] RUN_S  = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [BUCKET_WIDTH-1:0] cnt_q, cnt_d;

    // Entry layout: {valid, pointer}
    logic [HEAD_PTR_WIDTH:0] mem [DEPTH];

    logic [NSL*BUCKET_WIDTH-1:0] key_pad;
    logic [BUCKET_WIDTH-1:0]     bucket;
    logic [HEAD_PTR_WIDTH:0]     rd_ent, wr_ent;
    logic                        run, wr_act, accept, consume;

    always_comb begin
        key_pad = '0;
        key_pad[KEY_WIDTH-1:0] = cmd_key_i;
        bucket = '0;
        for (int i = 0; i < NSL; i++) begin
            bucket = bucket ^ key_pad[i*BUCKET_WIDTH +: BUCKET_WIDTH];
        end
    end

    assign run         = (state_q == RUN_S);
    assign init_done_o = run;
    assign cmd_ready_o = run && (!task_valid_o || task_ready_i);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign consume     = task_valid_o && task_ready_i;
    assign wr_act      = run && wr_en_i;
    assign wr_ent      = {wr_head_ptr_val_i, wr_head_ptr_i};

    // Write-first: a same-edge write to the looked-up bucket wins over the stored entry
    assign rd_ent = (wr_act && (wr_bucket_i == bucket)) ? wr_ent : mem[bucket];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT_S) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {BUCKET_WIDTH{1'b1}}) state_d = RUN_S;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= INIT_S;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The table has no reset; the INIT sweep clears it instead
    always_ff @(posedge clk_i) begin
        if (state_q == INIT_S) mem[cnt_q] <= '0;
        else if (wr_en_i)      mem[wr_bucket_i] <= wr_ent;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            task_key_o          <= '0;
            task_value_o        <= '0;
            task_cmd_o          <= '0;
            task_bucket_o       <= '0;
            task_head_ptr_o     <= '0;
            task_head_ptr_val_o <= 1'b0;
            task_valid_o        <= 1'b0;
        end else if (accept) begin
            task_key_o          <= cmd_key_i;
            task_value_o        <= cmd_value_i;
            task_cmd_o          <= cmd_cmd_i;
            task_bucket_o       <= bucket;
            task_head_ptr_o     <= rd_ent[HEAD_PTR_WIDTH-1:0];
            task_head_ptr_val_o <= rd_ent[HEAD_PTR_WIDTH];
            task_valid_o        <= 1'b1;
        end else if (consume) begin
            task_valid_o <= 1'b0;
        end else if (task_valid_o && wr_act && (wr_bucket_i == task_bucket_o)) begin
            // Keep a held task's head coherent with downstream updates
            task_head_ptr_o     <= wr_head_ptr_i;
            task_head_ptr_val_o <= wr_head_ptr_val_i;
        end
    end
endmodule

// File: tb/tb_head_table_lookup.sv
// Directed bench for head_table_lookup: init sweep, lookup, forwarding, stall, reset.
module tb_head_table_lookup;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] cmd_key_i;
    logic [15:0] cmd_value_i;
    logic [1:0]  cmd_cmd_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [31:0] task_key_o;
    logic [15:0] task_value_o;
    logic [1:0]  task_cmd_o;
    logic [7:0]  task_bucket_o;
    logic [7:0]  task_head_ptr_o;
    logic        task_head_ptr_val_o;
    logic        task_valid_o;
    logic        task_ready_i;
    logic        wr_en_i;
    logic [7:0]  wr_bucket_i;
    logic [7:0]  wr_head_ptr_i;
    logic        wr_head_ptr_val_i;
    logic        init_done_o;

    int total = 0;
    int passed = 0;
    int n;

    head_table_lookup dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_key_i(cmd_key_i), .cmd_value_i(cmd_value_i), .cmd_cmd_i(cmd_cmd_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .task_key_o(task_key_o), .task_value_o(task_value_o), .task_cmd_o(task_cmd_o),
        .task_bucket_o(task_bucket_o), .task_head_ptr_o(task_head_ptr_o),
        .task_head_ptr_val_o(task_head_ptr_val_o), .task_valid_o(task_valid_o),
        .task_ready_i(task_ready_i),
        .wr_en_i(wr_en_i), .wr_bucket_i(wr_bucket_i), .wr_head_ptr_i(wr_head_ptr_i),
        .wr_head_ptr_val_i(wr_head_ptr_val_i), .init_done_o(init_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cmd(input logic [31:0] k, input logic [15:0] v, input logic [1:0] c);
        cmd_key_i = k; cmd_value_i = v; cmd_cmd_i = c; cmd_valid_i = 1'b1;
    endtask

    task automatic wr(input logic [7:0] b, input logic [7:0] p, input logic vv);
        wr_en_i = 1'b1; wr_bucket_i = b; wr_head_ptr_i = p; wr_head_ptr_val_i = vv;
    endtask

    initial begin
        rst_i = 1'b1; task_ready_i = 1'b1; wr_en_i = 1'b0; wr_bucket_i = 8'h00;
        wr_head_ptr_i = 8'h00; wr_head_ptr_val_i = 1'b0;
        cmd(32'h0, 16'h0, 2'd0);
        // Writes during reset/INIT must be ignored
        wr(8'h00, 8'hAA, 1'b1);
        #23;
        chk("rst_ready", cmd_ready_o, 0);
        chk("rst_valid", task_valid_o, 0);
        chk("rst_init_done", init_done_o, 0);
        chk("rst_task_fields", {task_key_o, task_value_o, task_bucket_o, task_head_ptr_o, task_head_ptr_val_o}, 0);

        // 1: init sweep length with cmd_valid held high
        step();
        rst_i = 1'b0;
        n = 0;
        while (!cmd_ready_o && n < 400) begin n++; step(); end
        chk("init_cycles", n, 256);
        chk("init_done_rise", init_done_o, 1);
        wr_en_i = 1'b0;
        step();
        chk("t1_valid", task_valid_o, 1);
        chk("t1_bucket", task_bucket_o, 8'h00);
        chk("t1_head_val", task_head_ptr_val_o, 0);
        cmd_valid_i = 1'b0;
        step();
        chk("t1_drop", task_valid_o, 0);

        // 2: write then lookup
        wr(8'h08, 8'h3C, 1'b1);
        step();
        wr_en_i = 1'b0;
        cmd(32'h12345678, 16'hBEEF, 2'd1);
        step();
        cmd_valid_i = 1'b0;
        chk("t2_valid", task_valid_o, 1);
        chk("t2_bucket", task_bucket_o, 8'h08);
        chk("t2_head", task_head_ptr_o, 8'h3C);
        chk("t2_head_val", task_head_ptr_val_o, 1);
        chk("t2_value", task_value_o, 16'hBEEF);
        chk("t2_cmd", task_cmd_o, 2'd1);
        chk("t2_key", task_key_o, 32'h12345678);
        step();
        chk("t2_consumed", task_valid_o, 0);

        // 3: back-to-back, no bubbles
        cmd(32'h1, 16'h1, 2'd2);
        step();
        chk("t3_v1", task_valid_o, 1);
        chk("t3_b1", task_bucket_o, 8'h01);
        chk("t3_ready1", cmd_ready_o, 1);
        cmd(32'h2, 16'h2, 2'd2);
        step();
        chk("t3_v2", task_valid_o, 1);
        chk("t3_b2", task_bucket_o, 8'h02);
        cmd(32'h3, 16'h3, 2'd2);
        step();
        chk("t3_v3", task_valid_o, 1);
        chk("t3_b3", task_bucket_o, 8'h03);
        chk("t3_val3", task_value_o, 16'h3);
        cmd_valid_i = 1'b0;
        step();
        chk("t3_drop", task_valid_o, 0);

        // 4: stall with forwarding into the held task
        task_ready_i = 1'b0;
        cmd(32'h12345678, 16'hBEEF, 2'd1);
        step();
        chk("t4_valid", task_valid_o, 1);
        chk("t4_head_before", task_head_ptr_o, 8'h3C);
        chk("t4_ready_stall", cmd_ready_o, 0);
        cmd(32'h00000001, 16'h1111, 2'd3);
        wr(8'h08, 8'h55, 1'b1);
        step();
        wr_en_i = 1'b0;
        chk("t4_head_fwd", task_head_ptr_o, 8'h55);
        chk("t4_head_val_fwd", task_head_ptr_val_o, 1);
        chk("t4_key_held", task_key_o, 32'h12345678);
        chk("t4_bucket_held", task_bucket_o, 8'h08);
        chk("t4_ready_stall2", cmd_ready_o, 0);
        wr(8'h20, 8'h99, 1'b1);
        step();
        wr_en_i = 1'b0;
        chk("t4_no_fwd_other", task_head_ptr_o, 8'h55);
        cmd_valid_i = 1'b0;
        task_ready_i = 1'b1;
        step();
        chk("t4_consumed", task_valid_o, 0);

        // 5: same-edge write and accept (write-first)
        wr(8'h08, 8'h77, 1'b1);
        cmd(32'h12345678, 16'hCAFE, 2'd0);
        step();
        wr_en_i = 1'b0;
        cmd_valid_i = 1'b0;
        chk("t5_head", task_head_ptr_o, 8'h77);
        chk("t5_head_val", task_head_ptr_val_o, 1);

        // 6: reset while a task is held
        task_ready_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        chk("t6_valid_drop", task_valid_o, 0);
        chk("t6_init_done", init_done_o, 0);
        chk("t6_ready", cmd_ready_o, 0);
        task_ready_i = 1'b1;
        cmd(32'h12345678, 16'h0, 2'd0);
        step();
        rst_i = 1'b0;
        n = 0;
        while (!cmd_ready_o && n < 400) begin n++; step(); end
        chk("t6_init_cycles", n, 256);
        step();
        cmd_valid_i = 1'b0;
        chk("t6_bucket", task_bucket_o, 8'h08);
        chk("t6_head_val_cleared", task_head_ptr_val_o, 0);
        chk("t6_head_cleared", task_head_ptr_o, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
